vga_frame_checker: RTL and testbench
====================================

Name: vga_frame_checker

Overview:
- Passive receiver-side monitor for the VGA output stream: samples hsync/vsync/blank_n and 24-bit RGB on the pixel clock.
- Rebuilds pixel coordinates, checks 640x480 timing, and computes a per-frame 32-bit colour signature.
- Taps VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R/G/B in the top level. Used for on-board self-check (signature on HEX, lock on LEDR) and as a bench scoreboard.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, pixel clocks per line
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, lines per frame

Ports:
- clk  in  1  pixel clock (25 MHz, same as the VGA driver clock)
- rst  in  1  asynchronous, active-low reset
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- blank_n  in  1  high during active video
- red, green, blue  in  8 each  pixel colour
- clr_err  in  1  synchronous clear of sticky error flags
- pix_x  out  10  column index of current active pixel
- pix_y  out  10  row index of current active line
- frame_sig  out  32  signature of last completed frame
- frame_done  out  1  one-cycle pulse per completed frame
- frame_count  out  16  completed frames, wraps 0xFFFF->0
- locked  out  1  timing verified
- err_htotal, err_vtotal, err_hactive, err_vactive  out  1 each  sticky error flags

Behaviour:
- Reset values: all outputs 0; internal previous-sample registers of hsync/vsync/blank_n = 1/1/0; FSM = SEARCH.
- Edge events, registered-input compare in the same cycle:
  - hfall = prev_hs & ~hsync
  - vfall = prev_vs & ~vsync
  - aend = prev_blank & ~blank_n
- hclk: increments every clock. On hfall, check hclk == H_TOTAL-1 (only if h_seen), then hclk <= 0 and h_seen <= 1.
- vline: counts hfalls since last vfall, including an hfall on the vfall cycle. On vfall, check vline == V_TOTAL (only in LOCKED, or in MEASURE after first vfall), then clear.
- Active run:
  - While blank_n = 1: pix_x = run counter, which increments per pixel and clears on aend.
  - On aend: check count == H_ACTIVE, then pix_y++.
  - On vfall: check active-line count == V_ACTIVE, then pix_y <= 0.
- Signature: on each blank_n = 1 clock, sig <= {sig[30:0],sig[31]} ^ {8'h00,red,green,blue}. On vfall: frame_sig <= sig, including any same-cycle pixel, then sig <= 0.
- Failed checks set the matching err_* flag. Flags are sticky until clr_err. A failure on the same cycle as clr_err leaves the flag set.
- FSM:
  - SEARCH: ignore all checks. On first vfall -> MEASURE, clear all counters and h_seen.
  - MEASURE: checks active; a frame error flag (frame_err) records any failure. On vfall: if frame_err = 0 -> LOCKED, else stay. Clear frame_err.
  - LOCKED: locked = 1. On any check failure -> MEASURE, locked = 0 the next cycle.
- frame_done: pulses the cycle after each vfall in MEASURE or LOCKED; frame_count increments with it.
- Reset mid-frame returns to SEARCH. The first partial frame is never checked or signed.
- All counters are width-saturating, so no wrap before a check: hclk 10-bit saturates at 1023, vline at 1023. Saturated values fail the compare.

Test Plan:
- Small params (H_ACTIVE=4, H_TOTAL=8, V_ACTIVE=2, V_TOTAL=4), 3 nominal frames, all pixels RGB=0x000001 -> locked rises after 2nd vfall; frame_sig = 0x000000FF; frame_count = 2 after 3 vfalls; no error flags.
- Same stream, one line stretched to 9 clocks in frame 3 (while LOCKED) -> err_htotal = 1, locked drops; relocks after next clean frame; err_htotal stays 1 until clr_err pulse, then 0.
- One line with only 3 active pixels -> err_hactive = 1 at aend of that line; pix_x sequence 0,1,2 observed.
- Frame with 5 lines (V_TOTAL=4) -> err_vtotal = 1 at vfall; frame_done still pulses; frame_sig still latched.
- Assert rst low mid-frame while LOCKED -> all outputs 0 immediately; first post-reset vfall gives no frame_done and no errors.
- Default params driven by the real VGA driver at 25 MHz, constant colour 0 -> locked after 2 frames, frame_sig = 0, no error flags across 10 frames.

Source files
------------

// File: rtl/vga_frame_checker.sv
// Passive VGA timing/signature monitor; frame outputs and flags register one cycle after the triggering edge.
// No backpressure: it only observes the stream and never stalls it.
module vga_frame_checker #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank_n,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    input  logic        clr_err,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [31:0] frame_sig,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        locked,
    output logic        err_htotal,
    output logic        err_vtotal,
    output logic        err_hactive,
    output logic        err_vactive
);

    localparam logic [9:0] HT_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] HA_LEN  = 10'(H_ACTIVE);
    localparam logic [9:0] VT_LEN  = 10'(V_TOTAL);
    localparam logic [9:0] VA_LEN  = 10'(V_ACTIVE);
    localparam logic [9:0] SAT     = 10'd1023;

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      state, state_nxt;
    logic        prev_hs, prev_vs, prev_blank;
    logic [9:0]  hclk, vline, run_cnt;
    logic        h_seen, frame_err;
    logic [31:0] sig, sig_now;
    logic        hfall, vfall, aend, checking, restart;
    logic [9:0]  vline_now, lines_now;
    logic        fail_ht, fail_vt, fail_ha, fail_va, any_fail;

    assign hfall    = prev_hs & ~hsync;
    assign vfall    = prev_vs & ~vsync;
    assign aend     = prev_blank & ~blank_n;
    assign checking = (state != SEARCH);
    assign restart  = vfall & ~checking;

    // Counts include a same-cycle event so the frame-end compare sees the whole frame.
    assign vline_now = (hfall && vline != SAT)  ? vline + 10'd1 : vline;
    assign lines_now = (aend && pix_y != SAT)   ? pix_y + 10'd1 : pix_y;
    assign sig_now   = blank_n ? ({sig[30:0], sig[31]} ^ {8'h00, red, green, blue}) : sig;

    assign fail_ht  = checking & hfall & h_seen & (hclk != HT_LAST);
    assign fail_ha  = checking & aend & (run_cnt != HA_LEN);
    assign fail_vt  = checking & vfall & (vline_now != VT_LEN);
    assign fail_va  = checking & vfall & (lines_now != VA_LEN);
    assign any_fail = fail_ht | fail_ha | fail_vt | fail_va;

    assign pix_x  = blank_n ? run_cnt : 10'd0;
    assign locked = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH:  if (vfall) state_nxt = MEASURE;
            MEASURE: if (vfall && !frame_err && !any_fail) state_nxt = LOCKED;
            LOCKED:  if (any_fail) state_nxt = MEASURE;
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SEARCH;
            prev_hs     <= 1'b1;
            prev_vs     <= 1'b1;
            prev_blank  <= 1'b0;
            hclk        <= '0;
            vline       <= '0;
            run_cnt     <= '0;
            pix_y       <= '0;
            h_seen      <= 1'b0;
            frame_err   <= 1'b0;
            sig         <= '0;
            frame_sig   <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            err_htotal  <= 1'b0;
            err_vtotal  <= 1'b0;
            err_hactive <= 1'b0;
            err_vactive <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev_hs    <= hsync;
            prev_vs    <= vsync;
            prev_blank <= blank_n;

            if (restart || hfall)  hclk <= '0;
            else if (hclk != SAT)  hclk <= hclk + 10'd1;

            if (restart)    h_seen <= 1'b0;
            else if (hfall) h_seen <= 1'b1;

            vline <= vfall ? 10'd0 : vline_now;

            if (restart || aend)                 run_cnt <= '0;
            else if (blank_n && run_cnt != SAT)  run_cnt <= run_cnt + 10'd1;

            pix_y <= vfall ? 10'd0 : lines_now;
            sig   <= vfall ? 32'd0 : sig_now;

            // The partial frame seen while searching is never signed or counted.
            if (vfall && checking) frame_sig <= sig_now;
            frame_done <= vfall & checking;
            if (vfall && checking) frame_count <= frame_count + 16'd1;

            frame_err <= vfall ? 1'b0 : (checking & (frame_err | any_fail));

            err_htotal  <= fail_ht | (err_htotal  & ~clr_err);
            err_vtotal  <= fail_vt | (err_vtotal  & ~clr_err);
            err_hactive <= fail_ha | (err_hactive & ~clr_err);
            err_vactive <= fail_va | (err_vactive & ~clr_err);
        end
    end

endmodule

// File: tb/tb_vga_frame_checker.sv
// Directed bench for vga_frame_checker with a shrunken 4x2 active / 8x4 total raster.
module tb_vga_frame_checker;

    logic        clk = 1'b0;
    logic        rst, hsync, vsync, blank_n, clr_err;
    logic [23:0] rgb;
    logic [7:0]  red, green, blue;
    logic [9:0]  pix_x, pix_y;
    logic [31:0] frame_sig;
    logic        frame_done, locked;
    logic [15:0] frame_count;
    logic        err_htotal, err_vtotal, err_hactive, err_vactive;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int d0;

    always #5 clk = ~clk;

    assign {red, green, blue} = rgb;

    vga_frame_checker #(
        .H_ACTIVE(4), .H_TOTAL(8), .V_ACTIVE(2), .V_TOTAL(4)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
        .red(red), .green(green), .blue(blue), .clr_err(clr_err),
        .pix_x(pix_x), .pix_y(pix_y), .frame_sig(frame_sig), .frame_done(frame_done),
        .frame_count(frame_count), .locked(locked),
        .err_htotal(err_htotal), .err_vtotal(err_vtotal),
        .err_hactive(err_hactive), .err_vactive(err_vactive)
    );

    always @(negedge clk) if (frame_done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] errs();
        return 32'({err_htotal, err_vtotal, err_hactive, err_vactive});
    endfunction

    // One line: n_act active pixels from clock 0, hsync low on clocks 5..6.
    task automatic drive_line(input int n_act, input int n_tot, input logic vs,
                              input logic clr, input logic watch_x);
        for (int c = 0; c < n_tot; c++) begin
            @(negedge clk);
            blank_n = (c < n_act);
            hsync   = !(c == 5 || c == 6);
            vsync   = vs;
            clr_err = clr && (c == 0);
            if (watch_x && c < n_act) begin
                #1;
                chk($sformatf("pix_x_%0d", c), 32'(pix_x), 32'(c));
            end
        end
    endtask

    // Lines 0-1 active, vsync low for the whole last line.
    task automatic frame(input int first, input int n_lines, input int stretch_line,
                         input int short_line, input int clr_line);
        for (int l = first; l < n_lines; l++) begin
            drive_line((l < 2) ? ((l == short_line) ? 3 : 4) : 0,
                       (l == stretch_line) ? 9 : 8,
                       (l != n_lines - 1), (l == clr_line), (l == short_line));
        end
    endtask

    initial begin
        rst = 1'b0; hsync = 1'b1; vsync = 1'b1; blank_n = 1'b0; clr_err = 1'b0;
        rgb = 24'h000001;
        repeat (3) @(negedge clk);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_count",  32'(frame_count), 32'd0);
        chk("rst_sig",    frame_sig, 32'd0);
        chk("rst_done",   32'(frame_done), 32'd0);
        chk("rst_xy",     32'({pix_x, pix_y}), 32'd0);
        chk("rst_errs",   errs(), 32'd0);
        rst = 1'b1;

        frame(0, 4, -1, -1, -1);
        chk("f0_locked", 32'(locked), 32'd0);
        chk("f0_done",   32'(done_cnt), 32'd0);
        frame(0, 4, -1, -1, -1);
        chk("f1_locked", 32'(locked), 32'd1);
        chk("f1_count",  32'(frame_count), 32'd1);
        chk("f1_sig",    frame_sig, 32'h000000FF);
        frame(0, 4, -1, -1, -1);
        chk("f2_count",  32'(frame_count), 32'd2);
        chk("f2_done",   32'(done_cnt), 32'd2);
        chk("f2_sig",    frame_sig, 32'h000000FF);
        chk("f2_errs",   errs(), 32'd0);

        frame(0, 4, 1, -1, -1);
        chk("stretch_errs",   errs(), 32'b1000);
        chk("stretch_locked", 32'(locked), 32'd0);
        frame(0, 4, -1, -1, -1);
        chk("relock_locked",  32'(locked), 32'd1);
        chk("relock_errs",    errs(), 32'b1000);
        frame(0, 4, -1, -1, 0);
        chk("clr_errs",   errs(), 32'd0);
        chk("clr_locked", 32'(locked), 32'd1);

        frame(0, 4, -1, 0, -1);
        chk("short_errs",   errs(), 32'b0010);
        chk("short_locked", 32'(locked), 32'd0);
        chk("short_sig",    frame_sig, 32'h0000007F);

        frame(0, 5, -1, -1, -1);
        chk("vt_errs",  errs(), 32'b0110);
        chk("vt_sig",   frame_sig, 32'h000000FF);
        chk("vt_done",  32'(done_cnt), 32'd7);
        chk("vt_count", 32'(frame_count), 32'd7);

        rgb = 24'hFFFFFF;
        frame(0, 4, -1, -1, -1);
        chk("white_sig",    frame_sig, 32'h55000055);
        chk("white_locked", 32'(locked), 32'd1);

        rgb = 24'h000001;
        drive_line(4, 8, 1'b1, 1'b0, 1'b0);
        chk("mid_pix_y", 32'(pix_y), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_count",  32'(frame_count), 32'd0);
        chk("arst_sig",    frame_sig, 32'd0);
        chk("arst_errs",   errs(), 32'd0);
        chk("arst_pix_y",  32'(pix_y), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        d0 = done_cnt;
        frame(1, 4, -1, -1, -1);
        chk("post_done",  32'(done_cnt - d0), 32'd0);
        chk("post_count", 32'(frame_count), 32'd0);
        chk("post_errs",  errs(), 32'd0);
        frame(0, 4, -1, -1, -1);
        chk("post2_count",  32'(frame_count), 32'd1);
        chk("post2_locked", 32'(locked), 32'd1);
        chk("post2_sig",    frame_sig, 32'h000000FF);
        chk("post2_errs",   errs(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
